// File: rtl/iir_section_seq.sv
// First-order IIR section y = b0*x + b1*x1 + a1*y1 built around one shared external multiplier.
// Define IIR_SAT_EN to saturate y_out; otherwise y_out wraps to the low 4 bits.
module iir_section_seq #(
  parameter int ACC_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [3:0]       x_in,
  input  logic signed [3:0]       b0,
  input  logic signed [3:0]       b1,
  input  logic signed [3:0]       a1,
  input  logic                    hist_clr,
  output logic signed [3:0]       mult_a,
  output logic signed [3:0]       mult_b,
  input  logic signed [7:0]       mult_p,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [3:0]       y_out,
  output logic signed [ACC_W-1:0] acc_out
);

  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, DONE} state_t;

  state_t                  state_q;
  logic                    ready_q;
  logic                    outValid_q;
  logic signed [3:0]       x_q, b0_q, b1_q, a1_q;
  logic signed [3:0]       x1_q, y1_q, yOut_q;
  logic signed [ACC_W-1:0] acc_q, accOut_q;
  logic signed [ACC_W-1:0] prodExt_d, acc_d;
  logic signed [3:0]       y_d;
  logic                    inFire;

  assign in_ready  = ready_q && !hist_clr;
  assign inFire    = in_valid && in_ready;
  assign out_valid = outValid_q;
  assign y_out     = yOut_q;
  assign acc_out   = accOut_q;

  assign prodExt_d = {{(ACC_W-8){mult_p[7]}}, mult_p};
  assign acc_d     = (state_q == MUL0) ? prodExt_d : acc_q + prodExt_d;

`ifdef IIR_SAT_EN
  localparam logic signed [ACC_W-1:0] Y_MAX = 7;
  localparam logic signed [ACC_W-1:0] Y_MIN = -8;
  logic signed [ACC_W-1:0] shifted_d;

  assign shifted_d = acc_q >>> 3;

  always_comb begin
    if (shifted_d > Y_MAX)      y_d = 4'sd7;
    else if (shifted_d < Y_MIN) y_d = -4'sd8;
    else                        y_d = shifted_d[3:0];
  end
`else
  // Low 4 bits of acc >>> 3 are simply acc[6:3]; the arithmetic shift only affects discarded bits.
  assign y_d = acc_q[6:3];
`endif

  always_comb begin
    mult_a = '0;
    mult_b = '0;
    case (state_q)
      MUL0: begin
        mult_a = x_q;
        mult_b = b0_q;
      end
      MUL1: begin
        mult_a = x1_q;
        mult_b = b1_q;
      end
      MUL2: begin
        mult_a = y1_q;
        mult_b = a1_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      outValid_q <= 1'b0;
      x_q        <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
      a1_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      yOut_q     <= '0;
      acc_q      <= '0;
      accOut_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (hist_clr) begin
            x1_q <= '0;
            y1_q <= '0;
          end else if (inFire) begin
            x_q     <= x_in;
            b0_q    <= b0;
            b1_q    <= b1;
            a1_q    <= a1;
            ready_q <= 1'b0;
            state_q <= MUL0;
          end
        end
        MUL0: begin
          acc_q   <= acc_d;
          state_q <= MUL1;
        end
        MUL1: begin
          acc_q   <= acc_d;
          state_q <= MUL2;
        end
        MUL2: begin
          acc_q   <= acc_d;
          state_q <= DONE;
        end
        DONE: begin
          // First DONE cycle registers the result; it then holds until the consumer takes it.
          if (!outValid_q) begin
            outValid_q <= 1'b1;
            yOut_q     <= y_d;
            accOut_q   <= acc_q;
          end else if (out_ready) begin
            outValid_q <= 1'b0;
            x1_q       <= x_q;
            y1_q       <= yOut_q;
            ready_q    <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_section_seq.sv
// Self-checking bench for iir_section_seq: behavioural difference-equation model plus literal pins.
// Honours IIR_SAT_EN the same way the design does.
module tb_iir_section_seq;

  localparam int ACC_W = 10;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic signed [3:0]       x_in = '0;
  logic signed [3:0]       b0 = '0;
  logic signed [3:0]       b1 = '0;
  logic signed [3:0]       a1 = '0;
  logic                    hist_clr = 1'b0;
  logic signed [3:0]       mult_a;
  logic signed [3:0]       mult_b;
  logic signed [7:0]       mult_p;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic signed [3:0]       y_out;
  logic signed [ACC_W-1:0] acc_out;

  int total = 0;
  int bad = 0;
  int mx1 = 0;
  int my1 = 0;
  int expAcc = 0;
  int expY = 0;
  bit expActive = 1'b0;
  int lastY = 0;
  int lastAcc = 0;

  iir_section_seq #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .b0(b0), .b1(b1), .a1(a1), .hist_clr(hist_clr),
    .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out), .acc_out(acc_out)
  );

  assign mult_p = mult_a * mult_b;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void modelCompute(input int x, input int c0, input int c1, input int c2);
    int sh;
    expAcc = c0 * x + c1 * mx1 + c2 * my1;
    sh = expAcc >>> 3;
`ifdef IIR_SAT_EN
    if (sh > 7) sh = 7;
    if (sh < -8) sh = -8;
`else
    sh = ((sh + 8) & 15) - 8;
`endif
    expY = sh;
  endfunction

  // Result must match the model whenever a sample is pending; otherwise out_valid must stay low.
  initial begin
    forever begin
      @(negedge clk);
      if (expActive && out_valid) begin
        checkOutput("yOut", y_out, expY);
        checkOutput("accOut", acc_out, expAcc);
      end else if (!expActive) begin
        checkOutput("idleValid", out_valid, 0);
      end
    end
  end

  task automatic doReset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    hist_clr = 1'b0;
    #1;
    checkOutput("rstReady", in_ready, 0);
    checkOutput("rstValid", out_valid, 0);
    checkOutput("rstY", y_out, 0);
    checkOutput("rstAcc", acc_out, 0);
    checkOutput("rstMultA", mult_a, 0);
    checkOutput("rstMultB", mult_b, 0);
    mx1 = 0;
    my1 = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    #1 checkOutput("readyBeforeEdge", in_ready, 0);
    @(negedge clk);
    checkOutput("readyAfterReset", in_ready, 1);
  endtask

  task automatic applyStimulus(input logic signed [3:0] x, input logic signed [3:0] c0,
                               input logic signed [3:0] c1, input logic signed [3:0] c2,
                               input int holdCycles);
    int n;
    int lat;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("inReadyWait", in_ready, 1);
    x_in = x;
    b0 = c0;
    b1 = c1;
    a1 = c2;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    modelCompute(x, c0, c1, c2);
    expActive = 1'b1;
    lat = 0;
    while (lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    checkOutput("latency", lat, 4);
    lastY = y_out;
    lastAcc = acc_out;
    for (int i = 0; i < holdCycles; i++) begin
      in_valid = 1'b1;
      x_in = 4'sd7;
      checkOutput("doneReady", in_ready, 0);
      checkOutput("doneMultA", mult_a, 0);
      checkOutput("doneMultB", mult_b, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    mx1 = x;
    my1 = expY;
    expActive = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterOut", in_ready, 1);
  endtask

  initial begin
    doReset();

    applyStimulus(4, 4, 0, 0, 0);
    checkOutput("lit032Acc", lastAcc, 16);
    checkOutput("lit032Y", lastY, 2);

    doReset();
    applyStimulus(4, 4, 0, 4, 0);
    checkOutput("lit033Y0", lastY, 2);
    applyStimulus(0, 4, 0, 4, 0);
    checkOutput("lit033Acc", lastAcc, 8);
    checkOutput("lit033Y1", lastY, 1);

    doReset();
    applyStimulus(-8, -8, 0, 0, 0);
    checkOutput("lit034Acc", lastAcc, 64);
`ifdef IIR_SAT_EN
    checkOutput("lit034Y", lastY, 7);
`else
    checkOutput("lit034Y", lastY, -8);
`endif

    doReset();
    applyStimulus(4, 4, 0, 0, 3);
    checkOutput("lit035Y", lastY, 2);
    repeat (4) @(negedge clk);
    applyStimulus(-3, 7, -8, 5, 0);
    applyStimulus(7, -8, 7, -8, 1);
    applyStimulus(-8, 7, -8, 7, 2);
    applyStimulus(5, -6, 3, -2, 0);

    // Abort in MUL1 after history has been loaded with nonzero values.
    doReset();
    applyStimulus(4, 4, 0, 0, 0);
    @(negedge clk);
    x_in = 3;
    b0 = 5;
    b1 = 6;
    a1 = 2;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    checkOutput("mul0A", mult_a, 3);
    checkOutput("mul0B", mult_b, 5);
    @(posedge clk);
    #1;
    checkOutput("mul1A", mult_a, mx1);
    checkOutput("mul1B", mult_b, 6);
    rst_n = 1'b0;
    #1;
    checkOutput("abortValid", out_valid, 0);
    checkOutput("abortY", y_out, 0);
    checkOutput("abortAcc", acc_out, 0);
    checkOutput("abortMultA", mult_a, 0);
    mx1 = 0;
    my1 = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    applyStimulus(4, 4, 4, 4, 0);
    checkOutput("lit036Acc", lastAcc, 16);
    checkOutput("lit036Y", lastY, 2);

    doReset();
    applyStimulus(4, 4, 0, 0, 0);
    @(negedge clk);
    #1 hist_clr = 1'b1;
    in_valid = 1'b1;
    x_in = 4;
    b0 = 4;
    b1 = 0;
    a1 = 0;
    #1 checkOutput("clrReady", in_ready, 0);
    @(posedge clk);
    #1 hist_clr = 1'b0;
    in_valid = 1'b0;
    mx1 = 0;
    my1 = 0;
    repeat (6) @(negedge clk);
    applyStimulus(0, 0, 4, 4, 0);
    checkOutput("lit037Acc", lastAcc, 0);
    checkOutput("lit037Y", lastY, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iir_section_seq.md
IIR_SECTION_SEQ -- requirements
Module: iir_section_seq

Interface
REQ-001 SHALL have parameter ACC_W, default 10, meaning accumulator width in bits (legal >= 10).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have ports in_valid (input, 1) and in_ready (output, 1): input-sample handshake.
REQ-005 SHALL have port x_in, input, 4, signed Q1.3 sample.
REQ-006 SHALL have ports b0, b1, a1, input, 4 each, signed Q1.3 coefficients.
REQ-007 SHALL have port hist_clr, input, 1, synchronous clear of filter history.
REQ-008 SHALL have ports mult_a and mult_b, output, 4 each: operands to the external 4x4 signed multiplier.
REQ-009 SHALL have port mult_p, input, 8: combinational signed product of mult_a*mult_b, Q2.6.
REQ-010 SHALL have ports out_valid (output, 1) and out_ready (input, 1): output handshake.
REQ-011 SHALL have port y_out, output, 4, signed Q1.3 result.
REQ-012 SHALL have port acc_out, output, ACC_W, signed full-precision Q2.6 sum.

Function
REQ-013 SHALL compute y[n] = b0*x[n] + b1*x[n-1] + a1*y[n-1], reusing one multiplier sequentially.
REQ-014 SHALL use FSM states IDLE, MUL0, MUL1, MUL2, DONE.
REQ-015 SHALL assert in_ready only in IDLE with hist_clr low; in_valid&&in_ready latches x_in, b0, b1, a1 and moves to MUL0.
REQ-016 MUL0: mult_a=x, mult_b=b0, acc <= sign-extended mult_p; -> MUL1.
REQ-017 MUL1: mult_a=x1 (previous x), mult_b=b1, acc <= acc + mult_p; -> MUL2.
REQ-018 MUL2: mult_a=y1 (previous y_out), mult_b=a1, acc <= acc + mult_p; -> DONE.
REQ-019 SHALL drive mult_a and mult_b to 0 in IDLE and DONE.
REQ-020 DONE: out_valid=1; y_out and acc_out held stable until out_valid&&out_ready.
REQ-021 On out_valid&&out_ready: x1 <= latched x, y1 <= y_out, -> IDLE; in_ready rises the following cycle.
REQ-022 Latency: out_valid asserted exactly 4 clk edges after the accepting edge.
REQ-023 y_out SHALL be acc arithmetically shifted right by 3, reduced to 4 bits per REQ-030/031.
REQ-024 hist_clr in IDLE clears x1 and y1 to 0 and takes priority over in_valid (in_ready=0 that cycle); hist_clr outside IDLE is ignored.
REQ-025 in_valid outside IDLE SHALL be ignored; no sample is queued.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, acc, x1, y1, latched operands to 0.
REQ-027 During reset: in_ready=0, out_valid=0, y_out=0, acc_out=0, mult_a=0, mult_b=0.
REQ-028 Reset asserted mid-operation SHALL abort the sample with no output produced.
REQ-029 in_ready SHALL go high on the first clk edge after rst_n deasserts.

Configuration
REQ-030 With macro IIR_SAT_EN defined, y_out SHALL saturate to +7 / -8 when the shifted acc is out of 4-bit range.
REQ-031 Without IIR_SAT_EN, y_out SHALL be the low 4 bits of the shifted acc (two's-complement wrap).

Verification
REQ-032 b0=4,b1=0,a1=0,x=4 from reset -> acc_out=16, y_out=2, out_valid 4 cycles after accept.
REQ-033 b0=4,b1=0,a1=4: x=4 then x=0 -> outputs y=2 then acc_out=8, y_out=1.
REQ-034 b0=-8,x=-8 -> acc_out=64; y_out=7 with IIR_SAT_EN, y_out=-8 (4'b1000) without.
REQ-035 out_ready held low 3 cycles in DONE -> y_out/acc_out stable, in_ready=0, in_valid ignored; accepted on 4th cycle.
REQ-036 rst_n pulsed low in MUL1 -> out_valid never asserts, outputs 0; next sample x=4,b0=4 -> y_out=2 (history cleared).
REQ-037 hist_clr and in_valid together in IDLE after y1=2 -> sample not accepted; next sample with a1=4,x=0,b0=0 -> y_out=0.
